// File: rtl/meta_cache_mc_if.sv
// Signal bundle for meta_cache_mc: request channels, BRAM read port,
// response channel, maintenance controls and statistics.
interface meta_cache_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH-1:0]            req_ready;
    logic                         mem_en;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]        mem_rdata;
    logic                         meta_valid;
    logic [DATA_WIDTH-1:0]        meta_rdata;
    logic [CH_W-1:0]              meta_ch;
    logic                         meta_hit;
    logic                         meta_ready;
    logic                         flush;
    logic                         stat_clr;
    logic [31:0]                  hit_count;
    logic [31:0]                  miss_count;

    // Cache side
    modport slave (
        input  req_valid, req_addr, mem_rdata, meta_ready, flush, stat_clr,
        output req_ready, mem_en, mem_addr, meta_valid, meta_rdata, meta_ch,
               meta_hit, hit_count, miss_count
    );

    // Requester / memory / consumer side
    modport master (
        output req_valid, req_addr, mem_rdata, meta_ready, flush, stat_clr,
        input  req_ready, mem_en, mem_addr, meta_valid, meta_rdata, meta_ch,
               meta_hit, hit_count, miss_count
    );
endinterface

// File: rtl/meta_cache_mc.sv
// Direct-mapped metadata cache shared by NUM_CH round-robin request channels.
// One request in flight: hits answer the next cycle, misses read the BRAM
// once and install the returned word unless a flush arrived meanwhile.
module meta_cache_mc #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int CACHE_DEPTH = 64,
    parameter int NUM_CH      = 2,
    parameter int MEM_LAT     = 1
) (
    input  logic           clk,
    input  logic           rst,
    meta_cache_mc_if.slave bus
);
    localparam int IDX_W = $clog2(CACHE_DEPTH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS_WAIT, RESP} state_t;

    state_t                  state_reg;
    logic [CACHE_DEPTH-1:0]  line_valid_reg;
    logic [TAG_W-1:0]        tag_mem  [CACHE_DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem [CACHE_DEPTH];

    logic [CH_W-1:0]         last_grant_reg;
    logic [CH_W-1:0]         pend_ch_reg;
    logic [ADDR_WIDTH-1:0]   pend_addr_reg;
    logic [2:0]              wait_cnt_reg;
    logic                    flushed_reg;
    logic                    mem_en_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic                    meta_valid_reg;
    logic [DATA_WIDTH-1:0]   meta_rdata_reg;
    logic [CH_W-1:0]         meta_ch_reg;
    logic                    meta_hit_reg;
    logic [31:0]             hit_count_reg;
    logic [31:0]             miss_count_reg;

    logic [ADDR_WIDTH-1:0]   ch_addr [NUM_CH];
    logic [NUM_CH-1:0]       above_last;
    logic [NUM_CH-1:0]       pick_vec;
    logic                    grant_any;
    logic [CH_W-1:0]         grant_ch;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [IDX_W-1:0]        acc_idx;
    logic [TAG_W-1:0]        acc_tag;
    logic                    acc_hit;
    logic [IDX_W-1:0]        pend_idx;
    logic [TAG_W-1:0]        pend_tag;
    logic                    fill_done;
    logic                    install;

    // Per-channel address unpacking, rotation mask and one-hot ready
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_addr[gi]       = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign above_last[gi]    = (CH_W'(gi) > last_grant_reg);
            assign bus.req_ready[gi] = accept && (grant_ch == CH_W'(gi));
        end
    endgenerate

    // Round-robin: prefer requesters above the last grant, else wrap to the lowest
    assign pick_vec = (|(bus.req_valid & above_last)) ? (bus.req_valid & above_last)
                                                      : bus.req_valid;
    always_comb begin
        grant_any = |bus.req_valid;
        grant_ch  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pick_vec[c]) grant_ch = CH_W'(c);
        end
    end

    assign accept    = (state_reg == IDLE) && grant_any;
    assign acc_addr  = ch_addr[grant_ch];
    assign acc_idx   = acc_addr[IDX_W-1:0];
    assign acc_tag   = acc_addr[ADDR_WIDTH-1:IDX_W];
    assign acc_hit   = line_valid_reg[acc_idx] && (tag_mem[acc_idx] == acc_tag);

    // Fill uses only the registered request, never the live request bus
    assign pend_idx  = pend_addr_reg[IDX_W-1:0];
    assign pend_tag  = pend_addr_reg[ADDR_WIDTH-1:IDX_W];
    assign fill_done = (state_reg == MISS_WAIT) && (wait_cnt_reg == 3'(MEM_LAT));
    assign install   = fill_done && !flushed_reg && !bus.flush;

    // Request FSM with registered memory and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= CH_W'(NUM_CH - 1);
            pend_ch_reg    <= '0;
            pend_addr_reg  <= '0;
            wait_cnt_reg   <= '0;
            flushed_reg    <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            meta_valid_reg <= 1'b0;
            meta_rdata_reg <= '0;
            meta_ch_reg    <= '0;
            meta_hit_reg   <= 1'b0;
        end else begin
            mem_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        last_grant_reg <= grant_ch;
                        pend_ch_reg    <= grant_ch;
                        pend_addr_reg  <= acc_addr;
                        if (acc_hit) begin
                            state_reg      <= RESP;
                            meta_valid_reg <= 1'b1;
                            meta_rdata_reg <= data_mem[acc_idx];
                            meta_ch_reg    <= grant_ch;
                            meta_hit_reg   <= 1'b1;
                        end else begin
                            state_reg    <= MISS_WAIT;
                            mem_en_reg   <= 1'b1;
                            mem_addr_reg <= acc_addr;
                            wait_cnt_reg <= '0;
                            flushed_reg  <= 1'b0;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (bus.flush) flushed_reg <= 1'b1;
                    if (fill_done) begin
                        state_reg      <= RESP;
                        meta_valid_reg <= 1'b1;
                        meta_rdata_reg <= bus.mem_rdata;
                        meta_ch_reg    <= pend_ch_reg;
                        meta_hit_reg   <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 3'd1;
                    end
                end
                RESP: begin
                    if (bus.meta_ready) begin
                        state_reg      <= IDLE;
                        meta_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Valid bits: flush wins over a same-cycle install
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid_reg <= '0;
        end else if (bus.flush) begin
            line_valid_reg <= '0;
        end else if (install) begin
            line_valid_reg[pend_idx] <= 1'b1;
        end
    end

    // Tag/data storage, no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[pend_idx]  <= pend_tag;
            data_mem[pend_idx] <= bus.mem_rdata;
        end
    end

    // Saturating statistics; clear beats a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (bus.stat_clr) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (accept) begin
            if (acc_hit && (hit_count_reg != 32'hFFFF_FFFF))
                hit_count_reg <= hit_count_reg + 32'd1;
            if (!acc_hit && (miss_count_reg != 32'hFFFF_FFFF))
                miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign bus.mem_en     = mem_en_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.meta_valid = meta_valid_reg;
    assign bus.meta_rdata = meta_rdata_reg;
    assign bus.meta_ch    = meta_ch_reg;
    assign bus.meta_hit   = meta_hit_reg;
    assign bus.hit_count  = hit_count_reg;
    assign bus.miss_count = miss_count_reg;
endmodule

// File: tb/tb_meta_cache_mc.sv
// Self-checking bench for meta_cache_mc: table of single requests, then
// round-robin, back-pressure, flush and reset-during-miss sequences.
module tb_meta_cache_mc;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int NCH   = 2;
    localparam int LAT   = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meta_cache_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) bus ();

    meta_cache_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_DEPTH(DEPTH),
        .NUM_CH(NCH), .MEM_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] data;
        int          ch;
        bit          hit;
    } resp_t;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        bit          hit;
        logic [31:0] data;
        int          lat;
    } vec_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // BRAM model, one cycle latency: memory[i] = DEAD_0000 + i
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? (32'hDEAD_0000 + bus.mem_addr) : 32'hBADB_AD00;
    end

    // Scoreboard: pop and compare on every response handshake
    always @(negedge clk) begin
        if (!rst && bus.meta_valid && bus.meta_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%0h required=none", bus.meta_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp ch=%0d hit=%0d data=%h", bus.meta_ch, bus.meta_hit, bus.meta_rdata);
                check("resp_data", bus.meta_rdata, mon_e.data);
                check("resp_ch", bus.meta_ch, mon_e.ch);
                check("resp_hit", bus.meta_hit, mon_e.hit);
            end
        end
    end

    task automatic set_addr(input int ch, input logic [31:0] a);
        bus.req_addr[ch*AW +: AW] = a;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, bus.mem_en, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_meta_valid"}, bus.meta_valid, 0);
        check({tag, "_meta_rdata"}, bus.meta_rdata, 0);
        check({tag, "_meta_ch"}, bus.meta_ch, 0);
        check({tag, "_meta_hit"}, bus.meta_hit, 0);
        check({tag, "_hit_count"}, bus.hit_count, 0);
        check({tag, "_miss_count"}, bus.miss_count, 0);
    endtask

    // One isolated request: checks grant, memory traffic and accept-to-valid latency
    task automatic do_req(input int ch, input logic [31:0] addr, input bit hit,
                          input logic [31:0] data, input int lat, input bit fl);
        int n;
        int mem_seen;
        bit got;
        logic [NCH-1:0] oh;
        @(posedge clk); #1;
        set_addr(ch, addr);
        bus.req_valid[ch] = 1'b1;
        bus.flush = fl;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[ch]) got = 1;
        end
        check("req_ready", got, 1);
        if (!got) begin
            bus.req_valid = '0;
            bus.flush = 1'b0;
            return;
        end
        oh = '0;
        oh[ch] = 1'b1;
        check("req_ready_onehot", bus.req_ready, oh);
        exp_q.push_back('{data, ch, hit});
        @(posedge clk); #1;
        bus.req_valid[ch] = 1'b0;
        bus.flush = 1'b0;
        set_addr(ch, ~addr);
        n = 0;
        mem_seen = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.mem_en) begin
                mem_seen++;
                check("mem_addr", bus.mem_addr, addr);
            end
            if (bus.meta_valid) got = 1;
        end
        check("resp_latency", n, lat);
        check("mem_en_count", mem_seen, hit ? 0 : 1);
    endtask

    initial begin
        vec_t tbl[8];
        int exp_hits;
        int exp_miss;
        int grants;
        int exp_ch;
        int cyc;
        int g;
        bit got;

        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.meta_ready = 1'b1;
        bus.flush      = 1'b0;
        bus.stat_clr   = 1'b0;

        tbl[0] = '{0, 32'd10, 1'b0, 32'hDEAD_000A, 3};
        tbl[1] = '{1, 32'd10, 1'b1, 32'hDEAD_000A, 1};
        tbl[2] = '{0, 32'd5,  1'b0, 32'hDEAD_0005, 3};
        tbl[3] = '{1, 32'd69, 1'b0, 32'hDEAD_0045, 3};
        tbl[4] = '{0, 32'd5,  1'b0, 32'hDEAD_0005, 3};
        tbl[5] = '{1, 32'd5,  1'b1, 32'hDEAD_0005, 1};
        tbl[6] = '{0, 32'd74, 1'b0, 32'hDEAD_004A, 3};
        tbl[7] = '{1, 32'd10, 1'b0, 32'hDEAD_000A, 3};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // After reset channel 0 has priority
        @(posedge clk); #1;
        set_addr(0, 32'd100);
        set_addr(1, 32'd101);
        bus.req_valid = 2'b11;
        #2;
        check("rst_rr_priority", bus.req_ready, 2'b01);
        bus.req_valid = '0;

        // Table of isolated requests: cold miss, hit, eviction, refetch
        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].ch, tbl[i].addr, tbl[i].hit, tbl[i].data, tbl[i].lat, 1'b0);
            if (tbl[i].hit) exp_hits++;
            else exp_miss++;
        end
        @(negedge clk);
        check("hit_count_tbl", bus.hit_count, exp_hits);
        check("miss_count_tbl", bus.miss_count, exp_miss);

        @(posedge clk); #1 bus.stat_clr = 1'b1;
        @(posedge clk); #1 bus.stat_clr = 1'b0;
        check("stat_clr_hit", bus.hit_count, 0);
        check("stat_clr_miss", bus.miss_count, 0);

        // Both channels requesting continuously: grants must alternate
        set_addr(0, 32'd4);
        set_addr(1, 32'd8);
        bus.req_valid = 2'b11;
        grants = 0;
        exp_ch = 1 - tbl[7].ch;
        cyc = 0;
        while (grants < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (|(bus.req_ready & bus.req_valid)) begin
                g = bus.req_ready[1] ? 1 : 0;
                check("rr_grant", g, exp_ch);
                exp_q.push_back('{(g == 1) ? 32'hDEAD_0008 : 32'hDEAD_0004, g, grants >= 2});
                grants++;
                exp_ch = 1 - exp_ch;
                if (grants == 6) begin
                    @(posedge clk); #1 bus.req_valid = '0;
                end
            end
        end
        bus.req_valid = '0;
        check("rr_grants_done", grants, 6);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rr_drain", exp_q.size(), 0);
        check("rr_hit_count", bus.hit_count, 4);
        check("rr_miss_count", bus.miss_count, 2);

        // Back-pressure: response held stable, no new grants
        @(posedge clk); #1;
        bus.meta_ready = 1'b0;
        set_addr(0, 32'd4);
        bus.req_valid[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[0]) got = 1;
        end
        check("stall_accept", got, 1);
        exp_q.push_back('{32'hDEAD_0004, 0, 1'b1});
        @(posedge clk); #1;
        set_addr(1, 32'd8);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", bus.meta_valid, 1);
            check("stall_data", bus.meta_rdata, 32'hDEAD_0004);
            check("stall_ready_zero", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.meta_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_released", bus.meta_valid, 0);
        check("stall_one_handshake", exp_q.size(), 0);

        // Flush coincident with a hit still returns the hit, then 10 misses
        do_req(1, 32'd10, 1'b1, 32'hDEAD_000A, 1, 1'b1);
        do_req(0, 32'd10, 1'b0, 32'hDEAD_000A, 3, 1'b0);

        // Reset in the middle of a miss drops it entirely
        @(posedge clk); #1;
        set_addr(0, 32'd20);
        bus.req_valid[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[0]) got = 1;
        end
        check("rstmiss_accept", got, 1);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        check("rstmiss_mem_en", bus.mem_en, 1);
        check("rstmiss_mem_addr", bus.mem_addr, 32'd20);
        rst = 1'b1;
        #1;
        check_reset_outputs("midmiss");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", bus.meta_valid, 0);
        end
        do_req(0, 32'd20, 1'b0, 32'hDEAD_0014, 3, 1'b0);
        @(negedge clk);
        check("final_miss_count", bus.miss_count, 1);
        check("final_hit_count", bus.hit_count, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/meta_cache_mc.md
META_CACHE_MC -- requirements
Module: meta_cache_mc

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, metadata word width; ADDR_WIDTH, default 32, word address width; CACHE_DEPTH, default 64, direct-mapped lines (power of 2, >=2); NUM_CH, default 2, request channels (1..8); MEM_LAT, default 1, BRAM read latency in cycles (1..4).
REQ-002 SHALL derive IDX_W=clog2(CACHE_DEPTH), CH_W=max(1,clog2(NUM_CH)), tag = addr[ADDR_WIDTH-1:IDX_W], index = addr[IDX_W-1:0].
REQ-003 SHALL have ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_CH  per-channel request valid
req_addr  in  NUM_CH*ADDR_WIDTH  per-channel address, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NUM_CH  per-channel accept, one-hot or zero
mem_en  out  1  BRAM read enable, registered
mem_addr  out  ADDR_WIDTH  BRAM read address, registered
mem_rdata  in  DATA_WIDTH  BRAM data, valid MEM_LAT cycles after mem_en cycle
meta_valid  out  1  response valid
meta_rdata  out  DATA_WIDTH  response data
meta_ch  out  CH_W  channel that issued the response
meta_hit  out  1  1 = served from cache, 0 = filled from memory
meta_ready  in  1  consumer accept
flush  in  1  single-cycle pulse, invalidate all lines
stat_clr  in  1  clear statistics counters
hit_count  out  32  saturating hit counter
miss_count  out  32  saturating miss counter

Function
REQ-004 SHALL implement FSM states IDLE, MISS_WAIT, RESP; only IDLE accepts requests.
REQ-005 In IDLE SHALL grant one requesting channel round-robin, starting search at (last granted + 1) mod NUM_CH; req_ready SHALL be asserted only for the granted channel, combinationally, only in IDLE.
REQ-006 Acceptance = req_valid[c] && req_ready[c]; lookup SHALL use valid/tag arrays as registered at start of the accept cycle.
REQ-007 Hit accepted in cycle T: state->RESP, meta_valid=1 at T+1 with line data, meta_hit=1, meta_ch=c, hit_count+1.
REQ-008 Miss accepted in cycle T: state->MISS_WAIT, mem_en=1 and mem_addr=req_addr for exactly cycle T+1, miss_count+1; mem_rdata sampled at end of cycle T+1+MEM_LAT-1... i.e. in the cycle MEM_LAT after the mem_en cycle; line written (valid=1, tag, data) and meta_valid=1, meta_hit=0 at T+2+MEM_LAT.
REQ-009 mem_en SHALL be 0 in every other cycle; no request to memory on a hit.
REQ-010 In RESP, meta_valid/meta_rdata/meta_ch/meta_hit SHALL hold stable until meta_ready=1; on handshake -> IDLE next cycle; back-to-back hit throughput = 1 response per 2 cycles.
REQ-011 Miss to an index holding a different valid tag SHALL overwrite that line (direct-mapped eviction).
REQ-012 flush SHALL clear all valid bits at the next edge; flush coincident with a hit acceptance SHALL still return the hit; flush during MISS_WAIT SHALL still return the fetched data but SHALL NOT install the line.
REQ-013 Counters SHALL saturate at 32'hFFFF_FFFF; stat_clr SHALL zero both at next edge and take priority over a coincident increment.
REQ-014 Only the registered request (address, channel) SHALL be used after acceptance; req_addr changes after acceptance SHALL have no effect.

Reset
REQ-015 rst=1 SHALL asynchronously force: state IDLE, all valid bits 0, RR pointer so channel 0 has priority, mem_en=0, mem_addr=0, meta_valid=0, meta_rdata=0, meta_ch=0, meta_hit=0, hit_count=0, miss_count=0; data/tag arrays need not be cleared.
REQ-016 Reset during MISS_WAIT or RESP SHALL drop the transaction; mem_rdata returning after reset release SHALL be ignored and no response issued.

Verification (memory[i] = 32'hDEAD_0000 + i, MEM_LAT=1, NUM_CH=2)
REQ-017 ch0 reads addr 10 (cold) -> mem_en one cycle with mem_addr=10, response 0xDEAD000A, meta_hit=0, meta_ch=0, miss_count=1, 3 cycles accept-to-valid.
REQ-018 ch1 reads addr 10 again -> no mem_en, response 0xDEAD000A, meta_hit=1, meta_ch=1, 1 cycle accept-to-valid, hit_count=1.
REQ-019 Both channels request continuously (ch0 addr 4, ch1 addr 8) -> grants alternate 0,1,0,1; responses 0xDEAD0004/0xDEAD0008 tagged correctly.
REQ-020 Read 5 then 69 then 5 (CACHE_DEPTH=64) -> three misses, 69 returns 0xDEAD0045, final 5 re-fetched 0xDEAD0005.
REQ-021 Hold meta_ready=0 for 5 cycles after a response -> meta_valid and data stable, req_ready all 0; release -> one handshake, IDLE.
REQ-022 flush after caching addr 10, then read 10 -> miss, mem_en issued; assert rst mid-miss -> all outputs at reset values, no response, subsequent read of 20 returns 0xDEAD0014.
